progmem_loader_arb: RTL and testbench
=====================================

# progmem_loader_arb

Controller that owns the single port of the 16 KB byte-addressed program memory. After reset it holds the core in reset and fills program memory from a byte-serial loader stream. It assembles bytes into little-endian 32-bit words and issues one write per word. Once loading completes it releases the core and serves instruction fetches with a 1-cycle registered read response. It sits between the loader (UART/debug bridge), the core's fetch stage and the program memory.

## Interface
- `ADDR_W`, 14, program memory byte-address width
- `BASE_ADDR`, 14'h0000, byte address of the first loaded word (must be 4-aligned)
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `ld_valid` in 1: loader byte valid
- `ld_ready` out 1: loader byte accepted when `ld_valid && ld_ready`
- `ld_byte` in 8: loader data byte
- `ld_last` in 1: qualifies the final byte of the image
- `reload` in 1: single-cycle pulse; restart loading from `RUN`
- `core_hold` out 1: 1 keeps the core in reset
- `if_req` in 1: fetch request
- `if_addr` in ADDR_W: fetch byte address
- `if_gnt` out 1: fetch accepted this cycle
- `if_rvalid` out 1: fetch data valid
- `if_rdata` out 32: fetch data
- `mem_we` out 1: memory write enable; memory samples it on negedge `clk`
- `mem_addr` out ADDR_W: memory byte address
- `mem_din` out 32: memory write data
- `mem_dout` in 32: memory read data (combinational from `mem_addr`)
- `err_ovf` out 1: sticky; write pointer wrapped
- `err_verify` out 1: sticky; readback mismatch (see Configuration)

## Operation
- States: `FILL`, `WRITE`, `VERIFY` (macro only), `RUN`. Reset state is `FILL`.
- **FILL**
  - `ld_ready` = 1.
  - Each accepted byte goes into lane `cnt` (0..3) of a word register. The first byte lands in `[7:0]`.
  - Then `cnt` increments.
  - On the 4th byte or on `ld_last`, go to `WRITE`.
  - Unfilled lanes are padded with 8'hFF, the erased value.
- **WRITE**
  - `mem_we` = 1, `mem_addr` = `ptr`, `mem_din` = word. Hold for exactly one cycle.
  - Then `ptr` += 4 and `cnt` is cleared.
  - Next state is `VERIFY` if the macro is defined.
  - Otherwise: `RUN` if the last byte was seen, else `FILL`.
- **ptr wrap:** when `ptr` = 2^ADDR_W−4, the increment wraps `ptr` to 0 and sets `err_ovf`. Loading continues.
- **RUN**
  - `core_hold` = 0, `ld_ready` = 0.
  - `if_gnt` = `if_req`, combinationally. `mem_addr` = `if_addr`.
  - On grant, `mem_dout` is registered into `if_rdata` and `if_rvalid` is set for the next cycle.
  - Misaligned `if_addr` is passed through unchanged; memory reads are byte-granular.
- **reload in RUN**
  - A fetch granted in the same cycle still completes.
  - From the next cycle: state is `FILL`, `ptr` = `BASE_ADDR`, `cnt` = 0, `core_hold` = 1, `if_gnt` = 0.
  - Sticky errors are not cleared by `reload`; only `rst` clears them.
- `reload` outside `RUN` is ignored.
- `if_req` outside `RUN` is never granted.
- `mem_we` is 0 in every state except `WRITE`.

## Timing
- **Reset values:**
  - State `FILL`, `ptr` = `BASE_ADDR`, `cnt` = 0.
  - `core_hold` = 1, `ld_ready` = 1, `mem_we` = 0, `mem_din` = 0, `mem_addr` = `BASE_ADDR`.
  - `if_gnt` = 0, `if_rvalid` = 0, `if_rdata` = 0, `err_ovf` = 0, `err_verify` = 0.
- **Reset mid-WRITE:** `mem_we` drops asynchronously. The memory write happens only if the negedge already occurred.
- **Load throughput:** 4 byte cycles + 1 write cycle per word, plus 1 cycle when the macro is defined.
- **Hold release:** `core_hold` falls in the cycle after the final `WRITE` (or `VERIFY`) cycle.
- **Fetch latency:**
  - Grant at cycle N gives `if_rvalid` = 1 at N+1.
  - Back-to-back grants give `if_rvalid` high every cycle.
  - `if_rvalid` is low in any cycle following a non-grant.
- `ld_valid` may toggle freely. Bubbles in the loader stream do not change `cnt`.

## Configuration
- `PROGMEM_READBACK_EN`
  - **Defined:** after each `WRITE`, one `VERIFY` cycle drives `mem_addr` = the just-written address with `mem_we` = 0, and compares `mem_dout` to the written word. A mismatch sets `err_verify`. The next state is `RUN` or `FILL`, as after `WRITE`.
  - **Undefined:** no `VERIFY` state; `err_verify` is tied to 0.

## Test plan
- **Full two-word load:** stream B7 10 00 00 93 80 80 00, with `ld_last` on the 8th byte.
  - mem[0] = 0x000010B7 and mem[4] = 0x00808093.
  - `core_hold` falls 1 cycle after the 2nd write; exactly 2 `mem_we` pulses.
- **Partial last word:** stream 5 bytes 13 00 00 00 93 with `ld_last` on 93.
  - mem[4] = 0xFFFFFF93.
- **Fetch:** after the first load, `if_req` = 1 with `if_addr` = 4 at cycle N.
  - `if_gnt` = 1 at N; `if_rvalid` = 1 and `if_rdata` = 0x00808093 at N+1.
  - Addresses 0, 4, 0 back-to-back give 3 consecutive valid responses.
- **Reload with simultaneous fetch:** `reload` and `if_req` (`if_addr` = 0) in the same cycle.
  - That fetch returns 0x000010B7.
  - Next cycle: `core_hold` = 1, `if_gnt` = 0, `ld_ready` = 1.
  - A new 4-byte image lands at `BASE_ADDR`.
- **Wrap:** `BASE_ADDR` = 14'h3FFC with 8 bytes.
  - Words are written at 0x3FFC then 0x0000; `err_ovf` = 1 and stays 1 after `reload`.
- **Readback (macro defined):** the memory model corrupts the byte at 0x0001 on write.
  - `err_verify` = 1 after the first `VERIFY` cycle; loading still completes.
  - With the macro undefined, `err_verify` stays 0 and each word costs 5 cycles.

Source files
------------

// File: rtl/progmem_loader_arb_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : progmem_loader_arb_if                                        |
// | Description : Loader stream, fetch port and program-memory port bundle     |
// |               for progmem_loader_arb.                                      |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface progmem_loader_arb_if #(
  parameter int ADDR_W = 14
);
  // Loader byte stream
  logic              ld_valid;
  logic              ld_ready;
  logic [7:0]        ld_byte;
  logic              ld_last;
  logic              reload;
  logic              core_hold;
  // Instruction fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;
  // Program memory port
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic [31:0]       mem_dout;
  // Sticky status
  logic              err_ovf;
  logic              err_verify;

  modport slave (
    input  ld_valid, ld_byte, ld_last, reload, if_req, if_addr, mem_dout,
    output ld_ready, core_hold, if_gnt, if_rvalid, if_rdata,
           mem_we, mem_addr, mem_din, err_ovf, err_verify
  );

  modport master (
    output ld_valid, ld_byte, ld_last, reload, if_req, if_addr, mem_dout,
    input  ld_ready, core_hold, if_gnt, if_rvalid, if_rdata,
           mem_we, mem_addr, mem_din, err_ovf, err_verify
  );
endinterface
`default_nettype wire

// File: rtl/progmem_loader_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : progmem_loader_arb                                           |
// | Description : Owns the program-memory port: loads a byte-serial image as   |
// |               little-endian words while holding the core, then serves      |
// |               fetches. Optional readback: PROGMEM_READBACK_EN.             |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module progmem_loader_arb #(
  parameter int                ADDR_W    = 14,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input wire                   clk,
  input wire                   rst,
  progmem_loader_arb_if.slave  bus
);

  localparam logic [1:0] c_FILL   = 2'd0;
  localparam logic [1:0] c_WRITE  = 2'd1;
`ifdef PROGMEM_READBACK_EN
  localparam logic [1:0] c_VERIFY = 2'd2;
`endif
  localparam logic [1:0] c_RUN    = 2'd3;

  localparam logic [ADDR_W-1:0] c_STEP    = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] c_PTR_MAX = ~ADDR_W'(3);

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [1:0]        r_cnt;
  logic [31:0]       r_word;
  logic [31:0]       w_word_next;
  logic              r_last;
  logic              r_rvalid;
  logic [31:0]       r_rdata;
  logic              r_ovf;
  logic              w_ld_fire;
  logic              w_gnt;
  logic              w_adv;

  assign w_ld_fire = (r_state == c_FILL) && bus.ld_valid;
  assign w_gnt     = (r_state == c_RUN) && bus.if_req;

  // The pointer advances once the word is fully retired (after readback if present).
`ifdef PROGMEM_READBACK_EN
  assign w_adv = (r_state == c_VERIFY);
`else
  assign w_adv = (r_state == c_WRITE);
`endif

  // Lane merge: current byte into lane cnt; on the last byte, higher lanes read as erased.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign w_word_next[8*i +: 8] =
      (r_cnt == 2'(i))                   ? bus.ld_byte :
      (bus.ld_last && (r_cnt < 2'(i)))   ? 8'hFF       :
                                           r_word[8*i +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_FILL;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_FILL:   if (w_ld_fire && ((r_cnt == 2'd3) || bus.ld_last)) w_next_state = c_WRITE;
`ifdef PROGMEM_READBACK_EN
      c_WRITE:  w_next_state = c_VERIFY;
      c_VERIFY: w_next_state = r_last ? c_RUN : c_FILL;
`else
      c_WRITE:  w_next_state = r_last ? c_RUN : c_FILL;
`endif
      c_RUN:    if (bus.reload) w_next_state = c_FILL;
      default:  w_next_state = c_FILL;
    endcase
  end

  always_comb begin
    bus.ld_ready  = 1'b0;
    bus.core_hold = 1'b1;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = r_ptr;
    bus.if_gnt    = 1'b0;
    case (r_state)
      c_FILL:  bus.ld_ready = 1'b1;
      c_WRITE: bus.mem_we   = 1'b1;
      c_RUN: begin
        bus.core_hold = 1'b0;
        bus.if_gnt    = bus.if_req;
        bus.mem_addr  = bus.if_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr    <= BASE_ADDR;
      r_cnt    <= 2'd0;
      r_word   <= 32'd0;
      r_last   <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= 32'd0;
      r_ovf    <= 1'b0;
    end else begin
      r_rvalid <= w_gnt;
      if (w_gnt) r_rdata <= bus.mem_dout;
      if (w_ld_fire) begin
        r_word <= w_word_next;
        r_cnt  <= r_cnt + 2'd1;
        if (bus.ld_last) r_last <= 1'b1;
      end
      if (r_state == c_WRITE) r_cnt <= 2'd0;
      if (w_adv) begin
        r_ptr <= r_ptr + c_STEP;
        if (r_ptr == c_PTR_MAX) r_ovf <= 1'b1;
      end
      // Reload rewinds the loader; sticky errors survive until rst.
      if ((r_state == c_RUN) && bus.reload) begin
        r_ptr  <= BASE_ADDR;
        r_cnt  <= 2'd0;
        r_last <= 1'b0;
      end
    end
  end

`ifdef PROGMEM_READBACK_EN
  logic r_verify;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_verify <= 1'b0;
    else if ((r_state == c_VERIFY) && (bus.mem_dout != r_word)) r_verify <= 1'b1;
  end

  assign bus.err_verify = r_verify;
`else
  assign bus.err_verify = 1'b0;
`endif

  assign bus.mem_din   = r_word;
  assign bus.if_rvalid = r_rvalid;
  assign bus.if_rdata  = r_rdata;
  assign bus.err_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_progmem_loader_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_progmem_loader_arb                                        |
// | Description : Directed bench for progmem_loader_arb with byte-wide memory  |
// |               models; expectations follow PROGMEM_READBACK_EN.             |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_progmem_loader_arb;

`ifdef PROGMEM_READBACK_EN
  localparam int c_XTRA = 1;
`else
  localparam int c_XTRA = 0;
`endif

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   we_cnt = 0;
  int   cyc;
  logic corrupt_en = 1'b0;
  logic [7:0] mem0 [0:16383];
  logic [7:0] memw [0:16383];

  progmem_loader_arb_if #(.ADDR_W(14)) bus ();
  progmem_loader_arb_if #(.ADDR_W(14)) bus_w ();

  progmem_loader_arb #(.ADDR_W(14), .BASE_ADDR(14'h0000)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  progmem_loader_arb #(.ADDR_W(14), .BASE_ADDR(14'h3FFC)) dut_w (
    .clk(clk), .rst(rst), .bus(bus_w)
  );

  // Second instance sees the same stimulus; only its base address differs.
  assign bus_w.ld_valid = bus.ld_valid;
  assign bus_w.ld_byte  = bus.ld_byte;
  assign bus_w.ld_last  = bus.ld_last;
  assign bus_w.reload   = bus.reload;
  assign bus_w.if_req   = bus.if_req;
  assign bus_w.if_addr  = bus.if_addr;

  always_comb bus.mem_dout = {mem0[14'(bus.mem_addr + 14'd3)], mem0[14'(bus.mem_addr + 14'd2)],
                              mem0[14'(bus.mem_addr + 14'd1)], mem0[bus.mem_addr]};
  always_comb bus_w.mem_dout = {memw[14'(bus_w.mem_addr + 14'd3)], memw[14'(bus_w.mem_addr + 14'd2)],
                                memw[14'(bus_w.mem_addr + 14'd1)], memw[bus_w.mem_addr]};

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      we_cnt++;
      for (int i = 0; i < 4; i++)
        mem0[14'(bus.mem_addr + 14'(i))] <= bus.mem_din[8*i +: 8] ^
          ((corrupt_en && (14'(bus.mem_addr + 14'(i)) == 14'd1)) ? 8'hFF : 8'h00);
    end
    if (bus_w.mem_we === 1'b1)
      for (int j = 0; j < 4; j++)
        memw[14'(bus_w.mem_addr + 14'(j))] <= bus_w.mem_din[8*j +: 8];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] rd0(input logic [13:0] a);
    return {mem0[14'(a + 14'd3)], mem0[14'(a + 14'd2)], mem0[14'(a + 14'd1)], mem0[a]};
  endfunction

  function automatic logic [31:0] rdw(input logic [13:0] a);
    return {memw[14'(a + 14'd3)], memw[14'(a + 14'd2)], memw[14'(a + 14'd1)], memw[a]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Streams n bytes (stream order = left-to-right in s) and waits for hold release.
  task automatic load_image(input logic [63:0] s, input int n, output int c);
    int guard;
    c = 0;
    for (int k = 0; k < n; k++) begin
      bus.ld_valid = 1'b1;
      bus.ld_byte  = s[63-8*k -: 8];
      bus.ld_last  = (k == n - 1);
      guard = 0;
      while (!bus.ld_ready && guard < 10) begin
        step();
        c++;
        guard++;
      end
      step();
      c++;
    end
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    guard = 0;
    while (bus.core_hold && guard < 20) begin
      step();
      c++;
      guard++;
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.ld_valid = 1'b0;
    bus.ld_byte  = 8'h00;
    bus.ld_last  = 1'b0;
    bus.reload   = 1'b0;
    bus.if_req   = 1'b1;
    bus.if_addr  = 14'd8;
    for (int m = 0; m < 16384; m++) begin
      mem0[m] = 8'h00;
      memw[m] = 8'h00;
    end

    // Reset state, with a fetch request that must not be granted
    step();
    chk("rst_core_hold",  32'(bus.core_hold),  32'd1);
    chk("rst_ld_ready",   32'(bus.ld_ready),   32'd1);
    chk("rst_mem_we",     32'(bus.mem_we),     32'd0);
    chk("rst_mem_din",    bus.mem_din,         32'd0);
    chk("rst_mem_addr",   32'(bus.mem_addr),   32'h0000);
    chk("rst_mem_addr_w", 32'(bus_w.mem_addr), 32'h3FFC);
    chk("rst_if_gnt",     32'(bus.if_gnt),     32'd0);
    chk("rst_if_rvalid",  32'(bus.if_rvalid),  32'd0);
    chk("rst_if_rdata",   bus.if_rdata,        32'd0);
    chk("rst_err_ovf",    32'(bus.err_ovf),    32'd0);
    chk("rst_err_verify", 32'(bus.err_verify), 32'd0);
    rst        = 1'b0;
    bus.if_req = 1'b0;

    // Full two-word load; the wrap instance writes 0x3FFC then 0x0000
    load_image(64'hB710_0000_9380_8000, 8, cyc);
    chk("load1_cycles",   32'(cyc),            32'(10 + 2 * c_XTRA));
    chk("load1_we_cnt",   32'(we_cnt),         32'd2);
    chk("load1_mem0",     rd0(14'd0),          32'h000010B7);
    chk("load1_mem4",     rd0(14'd4),          32'h00808093);
    chk("wrap_mem3ffc",   rdw(14'h3FFC),       32'h000010B7);
    chk("wrap_mem0",      rdw(14'h0000),       32'h00808093);
    chk("wrap_err_ovf",   32'(bus_w.err_ovf),  32'd1);
    chk("load1_err_ovf",  32'(bus.err_ovf),    32'd0);
    chk("run_core_hold",  32'(bus.core_hold),  32'd0);
    chk("run_ld_ready",   32'(bus.ld_ready),   32'd0);

    // Single fetch
    bus.if_req  = 1'b1;
    bus.if_addr = 14'd4;
    #1;
    chk("fetch_gnt",      32'(bus.if_gnt),     32'd1);
    chk("fetch_mem_addr", 32'(bus.mem_addr),   32'd4);
    step();
    chk("fetch_rvalid",   32'(bus.if_rvalid),  32'd1);
    chk("fetch_rdata",    bus.if_rdata,        32'h00808093);
    bus.if_req = 1'b0;
    step();
    chk("fetch_idle_rvalid", 32'(bus.if_rvalid), 32'd0);

    // Back-to-back fetches 0, 4, 0 then a misaligned address
    bus.if_req  = 1'b1;
    bus.if_addr = 14'd0;
    step();
    chk("b2b0_rvalid", 32'(bus.if_rvalid), 32'd1);
    chk("b2b0_rdata",  bus.if_rdata,       32'h000010B7);
    bus.if_addr = 14'd4;
    step();
    chk("b2b1_rvalid", 32'(bus.if_rvalid), 32'd1);
    chk("b2b1_rdata",  bus.if_rdata,       32'h00808093);
    bus.if_addr = 14'd0;
    step();
    chk("b2b2_rvalid", 32'(bus.if_rvalid), 32'd1);
    chk("b2b2_rdata",  bus.if_rdata,       32'h000010B7);
    bus.if_addr = 14'd2;
    step();
    chk("misal_rdata", bus.if_rdata,       32'h80930000);
    bus.if_req = 1'b0;
    step();
    chk("b2b_end_rvalid", 32'(bus.if_rvalid), 32'd0);

    // Reload together with a fetch: the fetch still completes
    bus.reload  = 1'b1;
    bus.if_req  = 1'b1;
    bus.if_addr = 14'd0;
    #1;
    chk("rl_gnt",       32'(bus.if_gnt),     32'd1);
    step();
    bus.reload = 1'b0;
    chk("rl_rvalid",    32'(bus.if_rvalid),  32'd1);
    chk("rl_rdata",     bus.if_rdata,        32'h000010B7);
    chk("rl_core_hold", 32'(bus.core_hold),  32'd1);
    chk("rl_gnt_after", 32'(bus.if_gnt),     32'd0);
    chk("rl_ld_ready",  32'(bus.ld_ready),   32'd1);
    chk("rl_ovf_kept",  32'(bus_w.err_ovf),  32'd1);
    bus.if_req = 1'b0;

    // New 4-byte image lands at the base address
    load_image(64'h1305_A000_0000_0000, 4, cyc);
    chk("load2_cycles", 32'(cyc),           32'(5 + c_XTRA));
    chk("load2_we_cnt", 32'(we_cnt),        32'd3);
    chk("load2_mem0",   rd0(14'd0),         32'h00A00513);
    chk("load2_ovf",    32'(bus_w.err_ovf), 32'd1);

    // Partial last word is padded with erased bytes
    bus.reload = 1'b1;
    step();
    bus.reload = 1'b0;
    load_image(64'h1300_0000_9300_0000, 5, cyc);
    chk("part_cycles", 32'(cyc),    32'(7 + 2 * c_XTRA));
    chk("part_we_cnt", 32'(we_cnt), 32'd5);
    chk("part_mem0",   rd0(14'd0),  32'h00000013);
    chk("part_mem4",   rd0(14'd4),  32'hFFFFFF93);

    // Memory corrupts byte 0x0001 on write
    corrupt_en = 1'b1;
    bus.reload = 1'b1;
    step();
    bus.reload = 1'b0;
    load_image(64'h1122_3344_0000_0000, 4, cyc);
    chk("rb_cycles",    32'(cyc),            32'(5 + c_XTRA));
    chk("rb_err",       32'(bus.err_verify), 32'(c_XTRA));
    chk("rb_core_hold", 32'(bus.core_hold),  32'd0);
    chk("rb_mem0",      rd0(14'd0),          32'h4433DD11);
    bus.reload = 1'b1;
    step();
    bus.reload = 1'b0;
    corrupt_en = 1'b0;
    chk("rb_err_sticky", 32'(bus.err_verify), 32'(c_XTRA));

    // Reset lands mid-WRITE before the memory's negedge sample
    bus.ld_valid = 1'b1;
    bus.ld_last  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.ld_byte = 8'(8'hAA + 8'(k * 17));
      step();
    end
    bus.ld_valid = 1'b0;
    chk("mw_mem_we",  32'(bus.mem_we), 32'd1);
    chk("mw_mem_din", bus.mem_din,     32'hDDCCBBAA);
    #1;
    rst = 1'b1;
    #1;
    chk("mw_rst_we",     32'(bus.mem_we),     32'd0);
    chk("mw_rst_hold",   32'(bus.core_hold),  32'd1);
    chk("mw_rst_ovf",    32'(bus_w.err_ovf),  32'd0);
    chk("mw_rst_verify", 32'(bus.err_verify), 32'd0);
    @(negedge clk);
    #1;
    chk("mw_mem0",   rd0(14'd0),  32'h4433DD11);
    chk("mw_we_cnt", 32'(we_cnt), 32'd6);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
